// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: instruction fetch front end for the MIPS core.
// Owns the fetch PC, issues one word read at a time to a multi-cycle
// instruction memory over a req/ack handshake, and buffers the returned
// words with their addresses in a small FIFO that decode drains with
// valid/ready. A redirect flushes the queue and discards any in-flight word.
// Optional feature macro: PREFETCH_BYPASS_EN (zero-latency forwarding of an
// acked word straight to the outputs when the queue is empty).
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        instr_mem_q [DEPTH];
  logic [31:0]        pc_mem_q    [DEPTH];

  logic head_valid;
  logic ack_ok;
  logic bypass_taken;
  logic push;
  logic pop;

  // Handshake qualifiers and output selection (queue head, or the live word when bypassing).
  always_comb begin
    head_valid = (count_q != '0);
    ack_ok     = (state_q == WAIT) && mem_ack && !redirect;
`ifdef PREFETCH_BYPASS_EN
    if (ack_ok && !head_valid) begin
      instr_valid  = 1'b1;
      instr        = mem_rdata;
      instr_pc     = req_addr_q;
      bypass_taken = instr_ready;
    end else begin
      instr_valid  = head_valid;
      instr        = instr_mem_q[rd_ptr_q];
      instr_pc     = pc_mem_q[rd_ptr_q];
      bypass_taken = 1'b0;
    end
`else
    instr_valid  = head_valid;
    instr        = instr_mem_q[rd_ptr_q];
    instr_pc     = pc_mem_q[rd_ptr_q];
    bypass_taken = 1'b0;
`endif
    push     = ack_ok && !bypass_taken;
    pop      = head_valid && instr_ready;
    mem_req  = (state_q != IDLE);
    mem_addr = req_addr_q;
  end

  // Next-state logic: request FSM, fetch PC and FIFO bookkeeping; redirect overrides last.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    case (state_q)
      IDLE: begin
        if (!redirect && (count_q < FULL_CNT)) begin
          req_addr_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers: FSM state, fetch/request addresses, FIFO pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage: cleared on reset so the head reads as zero, written on each accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= mem_rdata;
      pc_mem_q[wr_ptr_q]    <= req_addr_q;
    end
  end

endmodule
